// File: rtl/hsi_m_rx_frame_buf.sv
// hsi_m_rx_frame_buf: master-side HSI receive frame buffer.
// Selects one decoder channel at each frame start and writes every received
// byte speculatively into a byte FIFO. A clean frame end commits the frame,
// and any error rolls it back.
// Optional feature macro: HSI_RX_CRC_CHECK_EN. When it is defined, frames
// carry a trailing CRC16-CCITT (poly 0x1021, init 0xFFFF, MSB first). A
// frame commits only when the residue is zero, and the two CRC bytes are
// stripped. When it is undefined, every byte is payload and the minimum
// frame length is one byte.
module hsi_m_rx_frame_buf #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [CW-1:0]     ch_sel,
  input  logic [8*NUM_CH-1:0] d,
  input  logic [NUM_CH-1:0] d_rdy,
  input  logic [NUM_CH-1:0] pb_err,
  input  logic [NUM_CH-1:0] frame_end,
  output logic [7:0]        q,
  output logic              q_valid,
  input  logic              q_ready,
  output logic              q_last,
  output logic              frame_ok,
  output logic [3:0]        rx_errs,
  input  logic              err_clr,
  output logic [AW:0]       level
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH + 1);

`ifdef HSI_RX_CRC_CHECK_EN
  // Two trailing CRC bytes are dropped on commit; a frame needs at least
  // one payload byte plus the CRC.
  localparam logic [AW:0] STRIP  = (AW+1)'(2);
  localparam logic [AW:0] MINLEN = (AW+1)'(3);

  // One byte of CRC16-CCITT, MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] c,
                                             input logic [7:0]  b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ b[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  logic [15:0] crc, crc_nx, crc_base, crc_tmp;
`else
  localparam logic [AW:0] STRIP  = (AW+1)'(0);
  localparam logic [AW:0] MINLEN = (AW+1)'(1);
`endif

  state_t          state, state_nx;
  logic [CW-1:0]   ch, ch_nx, cur_ch;
  logic [AW:0]     rd_ptr, cm_ptr, wr_ptr;
  logic [AW:0]     wr_nx, cm_nx, cnt, cnt_nx;
  logic [AW:0]     cnt_base, cnt_tmp, wr_tmp, last_tmp, occ;
  logic            full, take, rd_fire, frame_ok_nx;
  logic [3:0]      err_set;

  logic [7:0]      s_byte;
  logic            s_rdy, s_pb, s_fe;

  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic            last_set;
  logic [AW-1:0]   last_sa;

  logic [7:0]      mem [DEPTH];
  logic [DEPTH-1:0] last_flags;

  // Route the active channel's strobes; IDLE follows ch_sel live, a frame
  // in progress stays on the channel latched at its start.
  always_comb begin
    cur_ch = (state == IDLE) ? ch_sel : ch;
    s_byte = 8'h00;
    s_rdy  = 1'b0;
    s_pb   = 1'b0;
    s_fe   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_ch == CW'(k)) begin
        s_byte = d[8*k +: 8];
        s_rdy  = d_rdy[k]     & clk_en;
        s_pb   = pb_err[k]    & clk_en;
        s_fe   = frame_end[k] & clk_en;
      end
    end
  end

  assign occ     = wr_ptr - rd_ptr;
  assign full    = (occ == DEPTH_P);
  assign q_valid = (rd_ptr != cm_ptr);
  assign rd_fire = q_valid & q_ready;
  assign q       = mem[rd_ptr[AW-1:0]];
  assign q_last  = q_valid & last_flags[rd_ptr[AW-1:0]];
  assign level   = cm_ptr - rd_ptr;

  // Frame FSM: byte intake, error detection, commit and rollback decisions.
  always_comb begin
    state_nx    = state;
    ch_nx       = ch;
    cnt_nx      = cnt;
    wr_nx       = wr_ptr;
    cm_nx       = cm_ptr;
    err_set     = 4'h0;
    frame_ok_nx = 1'b0;
    mem_we      = 1'b0;
    mem_wa      = wr_ptr[AW-1:0];
    last_set    = 1'b0;
    last_sa     = '0;
    take        = 1'b0;
    cnt_base    = (state == IDLE) ? '0 : cnt;
    cnt_tmp     = cnt_base;
    wr_tmp      = wr_ptr;
    last_tmp    = '0;
`ifdef HSI_RX_CRC_CHECK_EN
    crc_nx      = crc;
    crc_base    = (state == IDLE) ? 16'hFFFF : crc;
    crc_tmp     = crc_base;
`endif

    if (clk_en) begin
      case (state)
        IDLE: begin
          ch_nx  = ch_sel;
          cnt_nx = '0;
`ifdef HSI_RX_CRC_CHECK_EN
          crc_nx = 16'hFFFF;
`endif
          take   = s_rdy;
        end
        RECV: take = 1'b1;
        DROP: begin
          if (s_fe) begin
            wr_nx    = cm_ptr;
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase

      if (take) begin
        state_nx = RECV;
        if (s_pb || (s_rdy && full)) begin
          // A byte arriving with a parity error is discarded; a byte with
          // no room left overflows the frame. Either way the frame dies.
          err_set[0] = s_pb;
          err_set[2] = ~s_pb;
          state_nx   = DROP;
          if (s_fe) begin
            wr_nx    = cm_ptr;
            state_nx = IDLE;
          end
        end else begin
          if (s_rdy) begin
            mem_we  = 1'b1;
            wr_tmp  = wr_ptr + ONE;
            cnt_tmp = (cnt_base == CNT_MAX) ? cnt_base : cnt_base + ONE;
`ifdef HSI_RX_CRC_CHECK_EN
            crc_tmp = crc16_step(crc_base, s_byte);
`endif
          end
          wr_nx  = wr_tmp;
          cnt_nx = cnt_tmp;
`ifdef HSI_RX_CRC_CHECK_EN
          crc_nx = crc_tmp;
`endif
          // A same-cycle byte is already folded into count and CRC here.
          if (s_fe) begin
            state_nx = IDLE;
            if (cnt_tmp < MINLEN) begin
              err_set[3] = 1'b1;
              wr_nx      = cm_ptr;
            end
`ifdef HSI_RX_CRC_CHECK_EN
            else if (crc_tmp != 16'h0000) begin
              err_set[1] = 1'b1;
              wr_nx      = cm_ptr;
            end
`endif
            else begin
              cm_nx       = wr_tmp - STRIP;
              wr_nx       = wr_tmp - STRIP;
              last_tmp    = wr_tmp - STRIP - ONE;
              last_sa     = last_tmp[AW-1:0];
              last_set    = 1'b1;
              frame_ok_nx = 1'b1;
            end
          end
        end
      end
    end
  end

  // Control state, pointers and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch       <= '0;
      cnt      <= '0;
      rd_ptr   <= '0;
      cm_ptr   <= '0;
      wr_ptr   <= '0;
      rx_errs  <= 4'h0;
      frame_ok <= 1'b0;
`ifdef HSI_RX_CRC_CHECK_EN
      crc      <= 16'hFFFF;
`endif
    end else begin
      state    <= state_nx;
      ch       <= ch_nx;
      cnt      <= cnt_nx;
      wr_ptr   <= wr_nx;
      cm_ptr   <= cm_nx;
      rd_ptr   <= rd_fire ? rd_ptr + ONE : rd_ptr;
      rx_errs  <= (err_clr ? 4'h0 : rx_errs) | err_set;
      frame_ok <= frame_ok_nx;
`ifdef HSI_RX_CRC_CHECK_EN
      crc      <= crc_nx;
`endif
    end
  end

  // Byte storage and last-byte flags; the set comes after the clear so a
  // one-byte commit marks the byte written in the same cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa]        <= s_byte;
      last_flags[mem_wa] <= 1'b0;
    end
    if (last_set) last_flags[last_sa] <= 1'b1;
  end

endmodule

// File: tb/tb_hsi_m_rx_frame_buf.sv
// Bench for hsi_m_rx_frame_buf (NUM_CH=2, DEPTH=16). Expectations follow
// HSI_RX_CRC_CHECK_EN when the bench is compiled with it.
module tb_hsi_m_rx_frame_buf;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
`ifdef HSI_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clk_en, q_ready, err_clr;
  logic [0:0]  ch_sel;
  logic [15:0] d_t;
  logic [1:0]  d_rdy_t, pb_t, fe_t;
  logic        noise;
  logic [31:0] cyc = '0;
  logic        nz;
  logic [15:0] d_w;
  logic [1:0]  d_rdy_w, pb_w, fe_w;

  logic [7:0]  q;
  logic        q_valid, q_last, frame_ok;
  logic [3:0]  rx_errs;
  logic [AW:0] level;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Channel-0 noise: toggling strobes that must be ignored while ch1 is active.
  assign nz      = noise & cyc[0];
  assign d_rdy_w = d_rdy_t | {1'b0, nz};
  assign pb_w    = pb_t    | {1'b0, nz};
  assign fe_w    = fe_t    | {1'b0, nz};
  assign d_w     = nz ? {d_t[15:8], 8'hEE} : d_t;

  hsi_m_rx_frame_buf #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .ch_sel(ch_sel),
    .d(d_w), .d_rdy(d_rdy_w), .pb_err(pb_w), .frame_end(fe_w),
    .q(q), .q_valid(q_valid), .q_ready(q_ready), .q_last(q_last),
    .frame_ok(frame_ok), .rx_errs(rx_errs), .err_clr(err_clr), .level(level)
  );

  typedef struct packed { logic [7:0] b; logic l; } ent_t;
  ent_t got_q[$];
  ent_t exp_q[$];
  int   ok_cnt = 0;
  int   gidx = 0;
  int   n_chk = 0, n_pass = 0;
  logic mid_hook = 1'b0;

  // Record every accepted byte and every frame_ok cycle.
  always @(negedge clk) begin
    if (q_valid && q_ready && !rst) got_q.push_back({q, q_last});
    if (frame_ok) ok_cnt = ok_cnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic send_byte(input int ch, input logic [7:0] b);
    d_t[8*ch +: 8] = b;
    d_rdy_t[ch] = 1'b1;
    tick();
    d_rdy_t[ch] = 1'b0;
  endtask

  // mode: 0 no CRC bytes, 1 good CRC, 2 corrupted CRC (CRC build only).
  task automatic send_frame(input int ch, input int n, input logic [7:0] first,
                            input int mode, output logic ok_now, output logic v_now);
    logic [15:0] c;
    logic [7:0]  b;
    logic        saved;
    c = 16'hFFFF;
    saved = ch_sel;
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      c = crc_step(c, b);
      send_byte(ch, b);
      if (mid_hook && i == 0) ch_sel = ~saved;
    end
    if (CRC_EN && mode != 0) begin
      send_byte(ch, c[15:8]);
      send_byte(ch, (mode == 2) ? (c[7:0] ^ 8'h01) : c[7:0]);
    end
    if (mid_hook) begin
      noise  = 1'b0;
      ch_sel = saved;
    end
    fe_t[ch] = 1'b1;
    tick();
    ok_now = frame_ok;
    v_now  = q_valid;
    fe_t[ch] = 1'b0;
  endtask

  task automatic push_exp(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) exp_q.push_back({first + 8'(i), (i == n - 1)});
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // Read everything out, then compare recorded bytes against expectations.
  task automatic drain(input string nm);
    int lim;
    q_ready = 1'b1;
    for (int i = 0; i < 200 && q_valid; i++) tick();
    chk({nm, " drain q_valid"}, q_valid, 0);
    q_ready = 1'b0;
    tick();
    chk({nm, " byte count"}, got_q.size(), exp_q.size());
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = gidx; i < lim; i++) begin
      chk($sformatf("%s byte[%0d]", nm, i), got_q[i].b, exp_q[i].b);
      chk($sformatf("%s last[%0d]", nm, i), got_q[i].l, exp_q[i].l);
    end
    gidx = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    while (exp_q.size() < gidx) exp_q.push_back({8'h00, 1'b0});
    chk({nm, " level after drain"}, level, 0);
  endtask

  typedef struct {
    int         ch;
    int         n;
    logic [7:0] first;
    int         mode;
    int         exp_ok;
    int         exp_lvl;
    int         exp_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic ok_now, v_now;
    int   o0, n3;

    tbl[0] = '{0, 9, 8'h31, 1, 1, 9, 0};
    tbl[1] = '{0, 9, 8'h31, 2, CRC_EN ? 0 : 1, CRC_EN ? 0 : 9, CRC_EN ? 2 : 0};
    tbl[2] = '{1, 2, 8'h50, 0, CRC_EN ? 0 : 1, CRC_EN ? 0 : 2, CRC_EN ? 8 : 0};
    tbl[3] = '{1, 1, 8'h60, 1, 1, 1, 0};
    tbl[4] = '{0, 0, 8'h00, 0, 0, 0, 0};
    tbl[5] = '{1, 5, 8'hA0, 1, 1, 5, 0};

    rst = 1'b1; clk_en = 1'b1; q_ready = 1'b0; err_clr = 1'b0; ch_sel = 1'b0;
    d_t = '0; d_rdy_t = '0; pb_t = '0; fe_t = '0; noise = 1'b0;
    repeat (3) tick();
    chk("reset q_valid", q_valid, 0);
    chk("reset q_last", q_last, 0);
    chk("reset frame_ok", frame_ok, 0);
    chk("reset rx_errs", rx_errs, 0);
    chk("reset level", level, 0);
    rst = 1'b0;
    tick();

    // Table-driven single frames into an empty FIFO.
    for (int t = 0; t < 6; t++) begin
      clr_err();
      ch_sel = 1'(tbl[t].ch);
      o0 = ok_cnt;
      send_frame(tbl[t].ch, tbl[t].n, tbl[t].first, tbl[t].mode, ok_now, v_now);
      chk($sformatf("vec%0d frame_ok latency", t), ok_now, tbl[t].exp_ok);
      chk($sformatf("vec%0d q_valid latency", t), v_now, tbl[t].exp_ok);
      tick();
      chk($sformatf("vec%0d frame_ok pulses", t), ok_cnt - o0, tbl[t].exp_ok);
      chk($sformatf("vec%0d level", t), level, tbl[t].exp_lvl);
      chk($sformatf("vec%0d rx_errs", t), rx_errs, tbl[t].exp_err);
      if (tbl[t].exp_ok != 0) push_exp(tbl[t].n, tbl[t].first);
      drain($sformatf("vec%0d", t));
    end

    // Overflow: 20-byte frame into 16-byte FIFO, then a small good frame.
    clr_err();
    ch_sel = 1'b0;
    o0 = ok_cnt;
    send_frame(0, 20, 8'h80, 1, ok_now, v_now);
    tick();
    chk("ovf frame_ok pulses", ok_cnt - o0, 0);
    chk("ovf rx_errs", rx_errs, 4);
    chk("ovf level", level, 0);
    n3 = CRC_EN ? 1 : 3;
    send_frame(0, n3, 8'hC0, 1, ok_now, v_now);
    chk("ovf next frame_ok", ok_now, 1);
    tick();
    chk("ovf next level", level, n3);
    chk("ovf sticky rx_errs", rx_errs, 4);
    push_exp(n3, 8'hC0);
    drain("ovf");

    // Parity error on byte 4, with err_clr in the same cycle: new error wins.
    o0 = ok_cnt;
    ch_sel = 1'b0;
    send_byte(0, 8'h11); send_byte(0, 8'h12); send_byte(0, 8'h13);
    d_t[7:0] = 8'h14; d_rdy_t[0] = 1'b1; pb_t[0] = 1'b1; err_clr = 1'b1;
    tick();
    d_rdy_t[0] = 1'b0; pb_t[0] = 1'b0; err_clr = 1'b0;
    send_byte(0, 8'h15); send_byte(0, 8'h16);
    fe_t[0] = 1'b1; tick(); fe_t[0] = 1'b0;
    tick();
    chk("pb rx_errs", rx_errs, 1);
    chk("pb level", level, 0);
    chk("pb frame_ok pulses", ok_cnt - o0, 0);

    // Channel-1 frame under channel-0 noise, ch_sel flipped mid-frame.
    ch_sel = 1'b1;
    noise = 1'b1;
    mid_hook = 1'b1;
    tick();
    o0 = ok_cnt;
    send_frame(1, 4, 8'h70, 1, ok_now, v_now);
    mid_hook = 1'b0;
    chk("ch1 frame_ok", ok_now, 1);
    tick();
    chk("ch1 frame_ok pulses", ok_cnt - o0, 1);
    chk("ch1 level", level, 4);
    chk("ch1 rx_errs", rx_errs, 1);
    push_exp(4, 8'h70);
    drain("ch1");

    // Back-to-back frames with continuous reads; wraps DEPTH over three times.
    clr_err();
    ch_sel = 1'b0;
    q_ready = 1'b1;
    o0 = ok_cnt;
    for (int f = 0; f < 11; f++) begin
      send_frame(0, 5, 8'(f * 5 + 16), 1, ok_now, v_now);
      push_exp(5, 8'(f * 5 + 16));
    end
    tick();
    chk("wrap frame_ok pulses", ok_cnt - o0, 11);
    chk("wrap rx_errs", rx_errs, 0);
    drain("wrap");

    // Reset mid-frame discards committed and speculative data alike.
    send_frame(0, 3, 8'hD0, 1, ok_now, v_now);
    send_byte(0, 8'hD8); send_byte(0, 8'hD9);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid-rst level", level, 0);
    chk("mid-rst q_valid", q_valid, 0);
    send_frame(0, 2, 8'hE0, 1, ok_now, v_now);
    chk("post-rst frame_ok", ok_now, 1);
    tick();
    chk("post-rst level", level, 2);
    push_exp(2, 8'hE0);
    drain("post-rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hsi_m_rx_frame_buf.md
# hsi_m_rx_frame_buf

Parametrised master-side receive frame buffer for the HSI link. It selects one of `NUM_CH` decoder byte streams and checks each frame with CRC16-CCITT on the fly. Each frame is written speculatively into a byte FIFO, then committed on a good frame end or rolled back on any error. It sits between the per-channel line decoders and the master's byte consumer, and adds multi-channel support, frame buffering with backpressure, and CRC stripping.

## Interface
Parameters:
- `NUM_CH`, 2: number of decoder input channels (1..8).
- `DEPTH`, 64: FIFO depth in bytes; power of two, ≥ 8. `AW = $clog2(DEPTH)`, `CW = max(1,$clog2(NUM_CH))`.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous, active-high.
- `clk_en` in 1: qualifies sampling of all decoder-side inputs; the output side ignores it.
- `ch_sel` in CW: selected channel; latched only at frame start.
- `d` in 8*NUM_CH: decoded bytes; channel k occupies `d[8k+7:8k]`.
- `d_rdy` in NUM_CH: per-channel byte strobe.
- `pb_err` in NUM_CH: per-channel parity-bit error strobe.
- `frame_end` in NUM_CH: per-channel end-of-frame strobe.
- `q` out 8: head FIFO byte (show-ahead).
- `q_valid` out 1: a committed byte is available.
- `q_ready` in 1: consumer accepts `q` when `q_valid & q_ready`.
- `q_last` out 1: `q` is the last payload byte of its frame.
- `frame_ok` out 1: one-cycle pulse on frame commit.
- `rx_errs` out 4: sticky errors; [0] parity, [1] CRC, [2] overflow, [3] short frame.
- `err_clr` in 1: clears `rx_errs`. A simultaneous new error wins.
- `level` out AW+1: count of committed, unread bytes.

## Operation
- Pointers are AW+1 bits: `rd_ptr`, `cm_ptr` (committed write), `wr_ptr` (speculative write). Speculative occupancy is `wr_ptr - rd_ptr`.
- Storage is a `DEPTH` x 8 byte array plus a `DEPTH` x 1 last-flag array.
- The CRC register uses polynomial 0x1021 and init 0xFFFF, MSB first, with no output XOR. It is updated over every received byte, including the two trailing CRC bytes. A good frame leaves a residue of 0x0000.
- The FSM has three states: IDLE, RECV, DROP. All transitions require `clk_en`.
  - IDLE: latch `ch_sel` into `ch`; CRC = 0xFFFF; byte count = 0. On `d_rdy[ch_sel]`, handle the byte as in RECV and go to RECV. A `frame_end` while in IDLE is ignored.
  - RECV, byte: if occupancy == DEPTH, set `rx_errs[2]` and go to DROP. Otherwise write the byte at `wr_ptr`, clear its last flag, increment `wr_ptr`, update the CRC, and increment the count (saturating at DEPTH+1).
  - RECV, `pb_err[ch]`: set `rx_errs[0]`, go to DROP.
  - RECV, `frame_end[ch]`: if count < 3, set `rx_errs[3]` and roll back. Else if CRC != 0, set `rx_errs[1]` and roll back. Else commit. In all cases go to IDLE.
  - DROP: ignore bytes; on `frame_end[ch]`, roll back and go to IDLE.
- Commit:
  - `cm_ptr <= wr_ptr - 2` and `wr_ptr <= wr_ptr - 2`, which strips the CRC bytes.
  - Set the last flag at `wr_ptr - 3`.
  - Pulse `frame_ok`.
- Rollback: `wr_ptr <= cm_ptr`.
- Output side:
  - `q = mem[rd_ptr]`, `q_last = last[rd_ptr]`.
  - `q_valid = (rd_ptr != cm_ptr)`.
  - `rd_ptr` increments on handshake; `level = cm_ptr - rd_ptr`.
- Channels other than `ch` are ignored entirely.

## Timing
- Reset values: `q_valid`=0, `q_last`=0, `frame_ok`=0, `rx_errs`=0, `level`=0; all pointers 0; FSM IDLE; CRC 0xFFFF. `q` equals `mem[0]`, which is don't-care until written.
- Same-cycle byte and `frame_end`: the byte is processed first, and the frame-end decision includes it. A same-cycle byte and `pb_err`: the byte is discarded, go to DROP.
- Commit latency: for a `frame_end` sampled at edge N, `frame_ok` is high during cycle N+1. `q_valid` rises in cycle N+1 if the FIFO was empty.
- A read and a commit in the same cycle are both applied; `level` reflects both next cycle.
- Reads may drain earlier frames while a new frame is being received. Space freed by reads is usable immediately.
- Wrap-around is handled by modulo pointer arithmetic. Full is `wr_ptr - rd_ptr == DEPTH`.
- `rst` mid-frame discards all buffered data, committed or not.

## Configuration
- `HSI_RX_CRC_CHECK_EN` defined: behaviour as described above (CRC check, 2-byte strip, minimum length 3).
- Not defined:
  - No CRC logic; `rx_errs[1]` is tied to 0.
  - Commit keeps all bytes: `cm_ptr <= wr_ptr`, last flag at `wr_ptr - 1`.
  - Minimum frame length is 1.

## Test plan
- Channel 0, bytes 0x31..0x39 ("123456789") then 0x29, 0xB1, then `frame_end`: `frame_ok` pulses once, `level`=9, reading gives 0x31..0x39 with `q_last` only on 0x39, `rx_errs`=0.
- Same frame with the last byte 0xB0: no `frame_ok`, `rx_errs[1]`=1, `level`=0, `wr_ptr` back to its pre-frame value.
- `DEPTH`=8, `q_ready`=0, 10-byte frame: `rx_errs[2]`=1, frame dropped, `level`=0. The next good 3-byte frame commits 1 byte.
- `pb_err` on byte 4 of a good frame, then a good frame on channel 1 (`ch_sel`=1 in IDLE) while channel 0 keeps toggling: only the channel-1 payload appears, and `rx_errs[0]`=1.
- Frames of 2 bytes and 0 bytes: 2 bytes gives `rx_errs[3]`=1; 0 bytes (`frame_end` in IDLE) gives no effect.
- Back-to-back good frames with continuous `q_ready`=1, pointers wrapping DEPTH three times: the byte order is exact, and `q_last` sits at each frame boundary.
